// File: rtl/adc_valid_strobe_pkg.sv
// Shared types and default sizes for the adc_valid_strobe sample qualifier.
// Contents:
//   state_e       per-channel FSM states (idle, acknowledge, wait for valid low)
//   NchDefault    default channel count (I and Q)
//   DataWDefault  default ADC sample width
//   CntWDefault   default decimation factor/counter width
package adc_valid_strobe_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StWait = 2'd2
  } state_e;

  localparam int unsigned NchDefault   = 2;
  localparam int unsigned DataWDefault = 12;
  localparam int unsigned CntWDefault  = 8;

endpackage

// File: rtl/adc_valid_strobe_chan.sv
// One channel of the ADC sample qualifier: detects a new sample on the adc_valid level, pulses
// adc_ready for one cycle, captures the data, decimates, and holds the result on a valid/ready
// output with a sticky overrun flag for dropped decimated samples.
// Optional build macro: ADC_VALID_STROBE_SYNC_EN adds a 2-flop synchronizer on adc_valid_i.
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   decim_i        effective decimation factor D (already forced to >= 1)
//   adc_valid_i    sample-present level from the ADC
//   adc_data_i     ADC sample
//   adc_ready_o    one-cycle acknowledge per accepted sample
//   out_valid_o    decimated sample available
//   out_data_o     decimated sample
//   out_ready_i    downstream accept
//   overrun_o      sticky: a decimated sample was dropped
//   overrun_clr_i  synchronous clear of overrun_o
module adc_valid_strobe_chan
  import adc_valid_strobe_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [CNT_W-1:0]  decim_i,
  input  logic              adc_valid_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              adc_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              overrun_o,
  input  logic              overrun_clr_i
);

  state_e              state_q;
  logic [DATA_W-1:0]   sample_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                adc_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                overrun_q;
  logic                valid_s;

`ifdef ADC_VALID_STROBE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], adc_valid_i};
    end
  end

  assign valid_s = sync_q[1];
`else
  assign valid_s = adc_valid_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      sample_q    <= '0;
      cnt_q       <= '0;
      adc_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      adc_ready_q <= 1'b0;
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      // Later assignments in the ACK branch override these: emit beats transfer, set beats clear.
      if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (valid_s) begin
            state_q     <= StAck;
            sample_q    <= adc_data_i;
            adc_ready_q <= 1'b1;
          end
        end
        StAck: begin
          state_q <= StWait;
          // >= so that lowering decim_i mid-count emits on the next sample.
          if (cnt_q >= decim_i - CNT_W'(1)) begin
            cnt_q <= '0;
            if (out_valid_q && !out_ready_i) begin
              overrun_q <= 1'b1;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= sample_q;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWait: begin
          if (!valid_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_ready_o = adc_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/adc_valid_strobe.sv
// Multi-channel ADC sample qualifier: NCH independent channels sharing the decimation factor
// and the overrun clear. A cfg_decim_i of 0 is treated as 1.
// Optional build macro: ADC_VALID_STROBE_SYNC_EN (per-channel adc_valid synchronizer).
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   cfg_decim_i      decimation factor shared by all channels
//   adc_valid_i      per-channel sample-present level
//   adc_data_i       channel c at [c*DATA_W +: DATA_W]
//   adc_ready_o      per-channel acknowledge pulse
//   out_valid_o      per-channel decimated sample available
//   out_data_o       decimated samples, same packing as adc_data_i
//   out_ready_i      per-channel downstream accept
//   overrun_o        per-channel sticky drop flag
//   overrun_clr_i    clears all overrun bits
module adc_valid_strobe
  import adc_valid_strobe_pkg::*;
#(
  parameter int unsigned NCH    = NchDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [CNT_W-1:0]      cfg_decim_i,
  input  logic [NCH-1:0]        adc_valid_i,
  input  logic [NCH*DATA_W-1:0] adc_data_i,
  output logic [NCH-1:0]        adc_ready_o,
  output logic [NCH-1:0]        out_valid_o,
  output logic [NCH*DATA_W-1:0] out_data_o,
  input  logic [NCH-1:0]        out_ready_i,
  output logic [NCH-1:0]        overrun_o,
  input  logic                  overrun_clr_i
);

  logic [CNT_W-1:0] decim_eff;

  assign decim_eff = (cfg_decim_i == '0) ? CNT_W'(1) : cfg_decim_i;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    adc_valid_strobe_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .decim_i       (decim_eff),
      .adc_valid_i   (adc_valid_i[c]),
      .adc_data_i    (adc_data_i[c*DATA_W +: DATA_W]),
      .adc_ready_o   (adc_ready_o[c]),
      .out_valid_o   (out_valid_o[c]),
      .out_data_o    (out_data_o[c*DATA_W +: DATA_W]),
      .out_ready_i   (out_ready_i[c]),
      .overrun_o     (overrun_o[c]),
      .overrun_clr_i (overrun_clr_i)
    );
  end

endmodule

// File: tb/tb_adc_valid_strobe.sv
module tb_adc_valid_strobe;

  localparam int NCH    = 2;
  localparam int DATA_W = 12;
  localparam int CNT_W  = 8;
`ifdef ADC_VALID_STROBE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [CNT_W-1:0]      cfg_decim = 8'd1;
  logic [NCH-1:0]        adc_valid = '0;
  logic [NCH*DATA_W-1:0] adc_data = '0;
  logic [NCH-1:0]        adc_ready;
  logic [NCH-1:0]        out_valid;
  logic [NCH*DATA_W-1:0] out_data;
  logic [NCH-1:0]        out_ready = '1;
  logic [NCH-1:0]        overrun;
  logic                  overrun_clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adc_valid_strobe #(
    .NCH    (NCH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .cfg_decim_i   (cfg_decim),
    .adc_valid_i   (adc_valid),
    .adc_data_i    (adc_data),
    .adc_ready_o   (adc_ready),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_ready_i   (out_ready),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sample is accepted on an edge where the (possibly delayed) valid is
  // high and valid has been seen low at least two edges after the previous acceptance.
  // The acknowledge lasts one cycle; the edge ending it counts the sample toward D.
  bit              m_rdy[NCH], m_ov[NCH], m_ovr[NCH], m_armed[NCH], m_s1[NCH], m_s2[NCH];
  logic [DATA_W-1:0] m_od[NCH], m_samp[NCH];
  int              m_pend[NCH], m_last[NCH];
  int              edge_n = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_rdy[c] = 0; m_ov[c] = 0; m_ovr[c] = 0; m_armed[c] = 1; m_s1[c] = 0; m_s2[c] = 0;
        m_od[c] = '0; m_samp[c] = '0; m_pend[c] = 0; m_last[c] = -10;
      end
    end else begin
      int d;
      edge_n++;
      d = (cfg_decim == 0) ? 1 : int'(cfg_decim);
      for (int c = 0; c < NCH; c++) begin
        bit v, emit, set;
        v = (LAT == 2) ? m_s2[c] : adc_valid[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = adc_valid[c];
        emit = 0;
        set = 0;
        if (m_rdy[c]) begin
          m_pend[c]++;
          if (m_pend[c] >= d) begin
            emit = 1;
            m_pend[c] = 0;
          end
        end
        if (emit) begin
          if (m_ov[c] && !out_ready[c]) set = 1;
          else begin
            m_ov[c] = 1;
            m_od[c] = m_samp[c];
          end
        end else if (m_ov[c] && out_ready[c]) begin
          m_ov[c] = 0;
        end
        if (set) m_ovr[c] = 1;
        else if (overrun_clr) m_ovr[c] = 0;
        m_rdy[c] = 0;
        if (v && m_armed[c]) begin
          m_rdy[c] = 1;
          m_armed[c] = 0;
          m_last[c] = edge_n;
          m_samp[c] = adc_data[c*DATA_W +: DATA_W];
        end else if (!v && edge_n >= m_last[c] + 2) begin
          m_armed[c] = 1;
        end
      end
    end
  end

  logic [DATA_W-1:0] rec0[$];

  always @(negedge clk) begin
    logic [NCH-1:0] e_rdy, e_ov, e_ovr;
    logic [NCH*DATA_W-1:0] e_od;
    for (int c = 0; c < NCH; c++) begin
      e_rdy[c] = m_rdy[c];
      e_ov[c] = m_ov[c];
      e_ovr[c] = m_ovr[c];
      e_od[c*DATA_W +: DATA_W] = m_od[c];
    end
    check("model adc_ready", 64'(adc_ready), 64'(e_rdy));
    check("model out_valid", 64'(out_valid), 64'(e_ov));
    check("model out_data", 64'(out_data), 64'(e_od));
    check("model overrun", 64'(overrun), 64'(e_ovr));
    if (out_valid[0] && out_ready[0]) rec0.push_back(out_data[DATA_W-1:0]);
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(int c, bit v, logic [DATA_W-1:0] d);
    adc_valid[c] = v;
    adc_data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic send(int c, logic [DATA_W-1:0] d);
    drive(c, 1'b1, d);
    tick(1);
    adc_valid[c] = 1'b0;
    tick(2 + LAT);
  endtask

  function automatic logic [DATA_W-1:0] rec_at(int i);
    return (rec0.size() > i) ? rec0[i] : '1;
  endfunction

  initial begin
    tick(2);
    check("reset adc_ready", 64'(adc_ready), 64'h0);
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data", 64'(out_data), 64'h0);
    check("reset overrun", 64'(overrun), 64'h0);
    reset = 1'b0;
    tick(1);

    // Single sample, D=1, valid held 5 edges.
    cfg_decim = 8'd1;
    out_ready = '1;
    drive(0, 1'b1, 12'h123);
    tick(1 + LAT);
    check("single ack pulse", 64'(adc_ready), 64'h1);
    check("single no early valid", 64'(out_valid), 64'h0);
    tick(1);
    check("single ack ends", 64'(adc_ready), 64'h0);
    check("single out_valid", 64'(out_valid), 64'h1);
    check("single out_data", 64'(out_data[DATA_W-1:0]), 64'h123);
    tick(1);
    check("single valid clears", 64'(out_valid), 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("single no second ack", 64'(adc_ready), 64'h0);
    end
    adc_valid[0] = 1'b0;
    tick(2 + LAT);

    // Decimation by 4 over samples 1..8.
    cfg_decim = 8'd4;
    rec0.delete();
    for (int i = 1; i <= 8; i++) send(0, DATA_W'(i));
    tick(2);
    check("decim4 count", 64'(rec0.size()), 64'd2);
    check("decim4 first", 64'(rec_at(0)), 64'd4);
    check("decim4 second", 64'(rec_at(1)), 64'd8);

    // cfg_decim=0 behaves as 1.
    cfg_decim = 8'd0;
    rec0.delete();
    send(0, 12'h021);
    send(0, 12'h022);
    tick(2);
    check("decim0 count", 64'(rec0.size()), 64'd2);
    check("decim0 first", 64'(rec_at(0)), 64'h021);
    check("decim0 second", 64'(rec_at(1)), 64'h022);

    // Backpressure and overrun.
    cfg_decim = 8'd1;
    out_ready = '0;
    send(0, 12'h00A);
    check("bp first held", 64'(out_valid[0]), 64'h1);
    check("bp first data", 64'(out_data[DATA_W-1:0]), 64'h00A);
    send(0, 12'h00B);
    check("bp data kept", 64'(out_data[DATA_W-1:0]), 64'h00A);
    check("bp overrun set", 64'(overrun), 64'h1);
    out_ready = '1;
    tick(1);
    check("bp transfer", 64'(out_valid[0]), 64'h0);
    check("bp overrun sticky", 64'(overrun), 64'h1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("bp overrun cleared", 64'(overrun), 64'h0);

    // Emit coincident with a transfer.
    out_ready = '0;
    send(0, 12'h011);
    drive(0, 1'b1, 12'h022);
    tick(1 + LAT);
    adc_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick(1);
    check("simul valid stays", 64'(out_valid[0]), 64'h1);
    check("simul new data", 64'(out_data[DATA_W-1:0]), 64'h022);
    check("simul no overrun", 64'(overrun), 64'h0);
    tick(2 + LAT);

    // Drop coincident with overrun_clr: set wins.
    out_ready = '0;
    send(0, 12'h033);
    drive(0, 1'b1, 12'h044);
    tick(1 + LAT);
    adc_valid[0] = 1'b0;
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("clr vs set overrun", 64'(overrun), 64'h1);
    check("clr vs set data", 64'(out_data[DATA_W-1:0]), 64'h033);
    out_ready = '1;
    overrun_clr = 1'b1;
    tick(2 + LAT);
    overrun_clr = 1'b0;

    // Staggered channels.
    drive(0, 1'b1, 12'h0AA);
    tick(1);
    drive(1, 1'b1, 12'h155);
    tick(1 + LAT);
    check("stagger out_valid", 64'(out_valid), 64'h1);
    check("stagger adc_ready", 64'(adc_ready), 64'h2);
    check("stagger ch0 data", 64'(out_data[DATA_W-1:0]), 64'h0AA);
    tick(1);
    check("stagger ch1 valid", 64'(out_valid), 64'h2);
    check("stagger ch1 data", 64'(out_data[2*DATA_W-1:DATA_W]), 64'h155);
    adc_valid = '0;
    tick(3 + LAT);

    // Reset while in ACK.
    drive(0, 1'b1, 12'h5A5);
    tick(1 + LAT);
    check("rst pre ack", 64'(adc_ready), 64'h1);
    reset = 1'b1;
    #1;
    check("rst ack drops", 64'(adc_ready), 64'h0);
    check("rst valid drops", 64'(out_valid), 64'h0);
    tick(2);
    adc_valid = '0;
    reset = 1'b0;
    tick(2);
    send(0, 12'h3C3);
    check("rst resume data", 64'(out_data[DATA_W-1:0]), 64'h3C3);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
